// File: rtl/player_pkg.sv
// player_pkg: shared types and default timing constants for the player input path.
// Contents: state_t (IDLE/LOCK/HOLD), dir_t (UP=0, DOWN=1), default parameter values.
// The lockout default is derived from the ship FSM's 6-cycle draw sequence
// plus its return to WAIT.
package player_pkg;
   typedef enum logic [1:0] {IDLE, LOCK, HOLD} state_t;
   typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;
   localparam int SHIP_SEQ_LEN = 6;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REPEAT_DELAY = 30;
   localparam int DEF_REPEAT_PERIOD = 8;
   localparam int DEF_LOCKOUT_CYCLES = SHIP_SEQ_LEN + 1;
endpackage

// File: rtl/player_input_ctrl_if.sv
// player_input_ctrl_if: board keys in, ship-FSM move requests out.
// Signals: key_up_n, key_down_n (raw, active-low), enable,
//          p_up, p_down (single-cycle requests), busy (lockout active).
// master = board/test side, slave = player_input_ctrl.
interface player_input_ctrl_if;
   logic key_up_n;
   logic key_down_n;
   logic enable;
   logic p_up;
   logic p_down;
   logic busy;
   modport master (output key_up_n, key_down_n, enable, input p_up, p_down, busy);
   modport slave (input key_up_n, key_down_n, enable, output p_up, p_down, busy);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus debounce counter for one push-button.
// Ports: clk, reset_n (sync, active-low), key_n (raw, active-low, async),
//        pressed (debounced level, 1 = pressed).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic pressed
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic s1, s2;
   logic [CW-1:0] cnt;
   // The counter only runs while the synced level disagrees with the accepted
   // level, so any return to agreement restarts the stability window.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         cnt <= '0;
         pressed <= 1'b0;
      end else begin
         s1 <= ~key_n;
         s2 <= s1;
         if (s2 == pressed) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            pressed <= s2;
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: turns two raw push-buttons into clean single-cycle
// p_up / p_down requests for the ship FSM, with arbitration, auto-repeat
// and a lockout window covering the ship's draw sequence.
// Ports: clk, reset_n (sync, active-low), bus (player_input_ctrl_if.slave:
//        key_up_n, key_down_n, enable in; p_up, p_down, busy out).
module player_input_ctrl
   import player_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
   input logic clk,
   input logic reset_n,
   player_input_ctrl_if.slave bus
);
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
   localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW = $clog2(TMAX + 1);
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
   logic up, down, req, hold_ok, fire, p_up_r, p_down_r;
   dir_t req_dir, dir, dir_nx;
   state_t state, state_nx;
   logic [LW-1:0] lock_cnt, lock_nx;
   logic [TW-1:0] rpt, rpt_nx;
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(clk), .reset_n(reset_n), .key_n(bus.key_up_n), .pressed(up)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(clk), .reset_n(reset_n), .key_n(bus.key_down_n), .pressed(down)
   );
   // Exactly one key pressed is a request; both or neither cancel.
   assign req = up ^ down;
   assign req_dir = down ? DOWN : UP;
   assign hold_ok = req && bus.enable && (req_dir == dir);
   always_comb begin
      state_nx = state;
      dir_nx = dir;
      lock_nx = lock_cnt;
      fire = 1'b0;
      // Repeat timer free-runs down to 0 outside IDLE; an expiry during LOCK
      // is therefore honoured on the first HOLD cycle.
      rpt_nx = (state != IDLE && rpt != '0) ? rpt - 1'b1 : rpt;
      case (state)
         IDLE: if (req && bus.enable) begin
            fire = 1'b1;
            dir_nx = req_dir;
            lock_nx = LOCK_LOAD;
            rpt_nx = DELAY_LOAD;
            state_nx = LOCK;
         end
         LOCK: begin
            lock_nx = (lock_cnt != '0) ? lock_cnt - 1'b1 : lock_cnt;
            state_nx = (lock_cnt == '0) ? HOLD : LOCK;
         end
         HOLD: if (!hold_ok) state_nx = IDLE;
         else if (rpt == '0) begin
            fire = 1'b1;
            lock_nx = LOCK_LOAD;
            rpt_nx = PERIOD_LOAD;
            state_nx = LOCK;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         dir <= UP;
         lock_cnt <= '0;
         rpt <= '0;
         p_up_r <= 1'b0;
         p_down_r <= 1'b0;
      end else begin
         state <= state_nx;
         dir <= dir_nx;
         lock_cnt <= lock_nx;
         rpt <= rpt_nx;
         p_up_r <= fire && (dir_nx == UP);
         p_down_r <= fire && (dir_nx == DOWN);
      end
   end
   // Every pulse enters LOCK on the same edge, so busy spans the pulse cycle
   // and the following lockout cycles.
   assign bus.p_up = p_up_r;
   assign bus.p_down = p_down_r;
   assign bus.busy = (state == LOCK);
endmodule

// File: tb/tb_player_input_ctrl.sv
// tb_player_input_ctrl: scoreboard bench for player_input_ctrl with a
// time-based reference model, directed scenarios and random key traffic.
module tb_player_input_ctrl;
   localparam int DB = 4, RD = 30, RP = 8, LK = 7, MAXC = 20000;
   typedef struct {int c; bit d;} ev_t;
   logic clk = 1'b0, reset_n = 1'b0;
   player_input_ctrl_if bus();
   player_input_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0, cyc = 0;
   bit hu[MAXC], hd[MAXC];
   bit db_u, db_d, act, mdir, exp_busy, prev_p, valid, rdir, fire;
   int chg_u, chg_d, last_p, next_rep;
   ev_t exp_q[$], seen[$];
   // A level is accepted once DB+1 consecutive synced samples (raw delayed
   // by two edges) differ from it, counting only samples after the last
   // change or reset.
   function automatic bit settle(input bit k, input int e, input bit lvl, input int since);
      if (e - DB <= since) return 1'b0;
      for (int i = e - DB; i <= e; i++)
         if ((k ? hd[i - 2] : hu[i - 2]) == lvl) return 1'b0;
      return 1'b1;
   endfunction
   // Reference model: pulses allowed once lockout has elapsed and the
   // repeat deadline has passed; evaluated on each edge from sampled inputs.
   always @(posedge clk) begin
      hu[cyc] = !bus.key_up_n;
      hd[cyc] = !bus.key_down_n;
      if (!reset_n) begin
         hu[cyc] = 1'b0;
         hd[cyc] = 1'b0;
         if (cyc > 0) begin
            hu[cyc - 1] = 1'b0;
            hd[cyc - 1] = 1'b0;
         end
         db_u = 1'b0; db_d = 1'b0; chg_u = cyc; chg_d = cyc;
         act = 1'b0; exp_busy = 1'b0;
      end else begin
         valid = db_u ^ db_d;
         rdir = db_d;
         fire = 1'b0;
         if (!act) begin
            if (valid && bus.enable) begin
               act = 1'b1; mdir = rdir; fire = 1'b1; next_rep = cyc + RD;
            end
         end else if (cyc >= last_p + LK + 1) begin
            if (!(valid && rdir == mdir && bus.enable)) act = 1'b0;
            else if (cyc >= next_rep) begin
               fire = 1'b1; next_rep = cyc + RP;
            end
         end
         if (fire) begin
            ev_t ev;
            last_p = cyc;
            ev.c = cyc; ev.d = mdir;
            exp_q.push_back(ev);
         end
         exp_busy = act && (cyc < last_p + LK);
         if (settle(1'b0, cyc, db_u, chg_u)) begin db_u = !db_u; chg_u = cyc; end
         if (settle(1'b1, cyc, db_d, chg_d)) begin db_d = !db_d; chg_d = cyc; end
      end
      cyc++;
   end
   // Monitor: pops the scoreboard whenever the DUT presents a pulse.
   initial begin
      ev_t ev;
      int c;
      prev_p = 1'b0;
      forever begin
         @(negedge clk);
         if (cyc == 0) continue;
         c = cyc - 1;
         n_chk++;
         if (bus.p_up && bus.p_down) begin
            n_fail++; $display("FAIL exclusive cycle %0d: p_up=%b p_down=%b, required not both", c, bus.p_up, bus.p_down);
         end
         n_chk++;
         if (bus.busy !== exp_busy) begin
            n_fail++; $display("FAIL busy cycle %0d: got %b required %b", c, bus.busy, exp_busy);
         end
         if (bus.p_up || bus.p_down) begin
            ev.c = c; ev.d = bus.p_down;
            seen.push_back(ev);
            n_chk++;
            if (prev_p) begin
               n_fail++; $display("FAIL back_to_back cycle %0d: pulse high in consecutive cycles", c);
            end
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL unexpected_pulse cycle %0d: got dir %0d, required none", c, bus.p_down);
            end else begin
               ev = exp_q.pop_front();
               if (ev.c != c || ev.d != bus.p_down) begin
                  n_fail++; $display("FAIL pulse: got cycle %0d dir %0d, required cycle %0d dir %0d", c, bus.p_down, ev.c, ev.d);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].c < c) begin
            n_chk++; n_fail++;
            $display("FAIL missing_pulse: got none, required cycle %0d dir %0d", exp_q[0].c, exp_q[0].d);
            void'(exp_q.pop_front());
         end
         prev_p = bus.p_up || bus.p_down;
      end
   end
   task automatic drive(input bit u, input bit d, input bit en, input int n);
      bus.key_up_n = !u;
      bus.key_down_n = !d;
      bus.enable = en;
      repeat (n) @(negedge clk);
   endtask
   // Compares pulses seen since t0 (relative cycle, dir) with a fixed list.
   task automatic check_rel(input string nm, input int t0, input int n, input int rel[6], input int dr[6]);
      int got[$], gd[$];
      foreach (seen[i]) if (seen[i].c >= t0) begin
         got.push_back(seen[i].c - t0);
         gd.push_back(int'(seen[i].d));
      end
      n_chk++;
      if (got.size() != n) begin
         n_fail++; $display("FAIL %s count: got %0d pulses, required %0d", nm, got.size(), n);
      end
      for (int i = 0; i < n && i < got.size(); i++) begin
         n_chk++;
         if (got[i] != rel[i] || gd[i] != dr[i]) begin
            n_fail++; $display("FAIL %s pulse %0d: got cycle %0d dir %0d, required cycle %0d dir %0d", nm, i, got[i], gd[i], rel[i], dr[i]);
         end
      end
   endtask
   initial begin
      int t0;
      bus.key_up_n = 1'b1;
      bus.key_down_n = 1'b1;
      bus.enable = 1'b1;
      reset_n = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      drive(0, 0, 1, 5);
      t0 = cyc; drive(1, 0, 1, 12); drive(0, 0, 1, 40);
      check_rel("single", t0, 1, '{7, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
      t0 = cyc; drive(0, 1, 1, 3); drive(0, 0, 1, 20);
      check_rel("glitch", t0, 0, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
      t0 = cyc; drive(0, 1, 1, 70); drive(0, 0, 1, 40);
      check_rel("repeat", t0, 6, '{7, 37, 45, 53, 61, 69}, '{1, 1, 1, 1, 1, 1});
      t0 = cyc; drive(1, 0, 1, 20); drive(1, 1, 1, 40); drive(0, 1, 1, 30); drive(0, 0, 1, 40);
      check_rel("conflict", t0, 2, '{7, 67, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0});
      t0 = cyc; drive(1, 0, 0, 30); drive(1, 0, 1, 5); drive(0, 0, 1, 40);
      check_rel("enable", t0, 1, '{30, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
      t0 = cyc; drive(1, 0, 1, 9);
      reset_n = 1'b0; drive(1, 0, 1, 1);
      reset_n = 1'b1; drive(1, 0, 1, 15); drive(0, 0, 1, 40);
      check_rel("reset_lock", t0, 2, '{7, 17, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
      for (int s = 0; s < 200; s++) begin
         bit u, d, en;
         int len;
         u = 1'($urandom_range(0, 1));
         d = ($urandom_range(0, 2) == 0);
         en = ($urandom_range(0, 7) != 0);
         len = $urandom_range(0, 1) ? $urandom_range(1, 6) : $urandom_range(7, 70);
         if ($urandom_range(0, 30) == 0) begin
            reset_n = 1'b0; drive(u, d, en, 1); reset_n = 1'b1;
         end
         drive(u, d, en, len);
      end
      drive(0, 0, 1, 60);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL drain: %0d expected pulses never seen, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end
endmodule
